// File: rtl/cordic_rr_scheduler_pkg.sv
// Shared state encoding and Q2.10 fixed-point constants for the CORDIC request scheduler.
package cordic_rr_scheduler_pkg;

   localparam int unsigned CORDIC_W = 12;

   localparam logic [CORDIC_W-1:0] ONE    = 12'h400;
   localparam logic [CORDIC_W-1:0] PI_4   = 12'h324;
   localparam logic [CORDIC_W-1:0] K_INIT = 12'd622;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StBusy,
      StRelease,
      StRecover
   } sched_state_e;

endpackage

// File: rtl/cordic_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: scans from the slot after the last grant and
// returns the first active request as a one-hot grant plus its index.
module cordic_rr_scheduler_rr_arbiter #(
   parameter int unsigned N = 4,
   localparam int unsigned IdxW = $clog2(N)
) (
   input  logic [N-1:0]    i_req,
   input  logic [IdxW-1:0] i_last_grant,
   output logic [N-1:0]    o_grant,
   output logic [IdxW-1:0] o_idx,
   output logic            o_valid
);

   logic [IdxW-1:0] w_cand;

   always_comb begin
      o_grant = '0;
      o_idx   = '0;
      o_valid = 1'b0;
      w_cand  = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         w_cand = IdxW'((32'(i_last_grant) + k) % N);
         if (!o_valid && i_req[w_cand]) begin
            o_valid         = 1'b1;
            o_idx           = w_cand;
            o_grant[w_cand] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cordic_rr_scheduler.sv
// Shares one iterative sin/cos CORDIC engine among N requesters with round-robin
// arbitration, start/ready sequencing and a watchdog that resets a hung engine.
module cordic_rr_scheduler
   import cordic_rr_scheduler_pkg::*;
#(
   parameter int unsigned N       = 4,
   parameter int unsigned W       = CORDIC_W,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic           i_clock,
   input  logic           i_reset,       // active-low, synchronous
   input  logic [N-1:0]   i_req_valid,
   input  logic [N*W-1:0] i_req_angle,
   output logic [N-1:0]   o_req_ready,
   output logic [N-1:0]   o_resp_valid,
   output logic           o_resp_err,
   output logic [W-1:0]   o_resp_sin,
   output logic [W-1:0]   o_resp_cos,
   output logic           o_eng_start,
   output logic [W-1:0]   o_eng_angle,
   output logic           o_eng_reset,
   input  logic           i_eng_ready,
   input  logic [W-1:0]   i_eng_sin,
   input  logic [W-1:0]   i_eng_cos,
   output logic           o_busy
);

   localparam int unsigned IdxW = $clog2(N);
   localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
   localparam logic [WdW-1:0] WdMax = WdW'(TIMEOUT);

   sched_state_e    r_state;
   logic [IdxW-1:0] r_id;
   logic [IdxW-1:0] r_last_grant;
   logic [W-1:0]    r_angle;
   logic [WdW-1:0]  r_wdog;
   logic [N-1:0]    r_resp_valid;
   logic            r_resp_err;
   logic [W-1:0]    r_resp_sin;
   logic [W-1:0]    r_resp_cos;
   logic            r_eng_start;
   logic            r_eng_rst;
   logic            r_rec_second;

   logic [N-1:0]    w_grant;
   logic [IdxW-1:0] w_grant_idx;
   logic            w_grant_valid;
   logic            w_accept;
   logic [W-1:0]    w_grant_angle;

   cordic_rr_scheduler_rr_arbiter #(
      .N (N)
   ) u_arbiter (
      .i_req        (i_req_valid),
      .i_last_grant (r_last_grant),
      .o_grant      (w_grant),
      .o_idx        (w_grant_idx),
      .o_valid      (w_grant_valid)
   );

   // Accept is a same-cycle handshake: the angle is latched on the edge ending the ready pulse.
   assign w_accept = i_reset && (r_state == StIdle) && w_grant_valid;

   always_comb begin
      w_grant_angle = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (w_grant[i]) w_grant_angle = i_req_angle[i*W +: W];
      end
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         r_state      <= StIdle;
         r_id         <= '0;
         r_last_grant <= IdxW'(N - 1);
         r_angle      <= '0;
         r_wdog       <= '0;
         r_resp_valid <= '0;
         r_resp_err   <= 1'b0;
         r_resp_sin   <= '0;
         r_resp_cos   <= '0;
         r_eng_start  <= 1'b0;
         r_eng_rst    <= 1'b0;
         r_rec_second <= 1'b0;
      end else begin
         r_resp_valid <= '0;
         unique case (r_state)
            StIdle: begin
               if (w_accept) begin
                  r_id         <= w_grant_idx;
                  r_last_grant <= w_grant_idx;
                  r_angle      <= w_grant_angle;
                  r_eng_start  <= 1'b1;
                  r_wdog       <= '0;
                  r_state      <= StIssue;
               end
            end
            StIssue, StBusy: begin
               // ISSUE ignores ready: it may still be the previous job's stale result.
               if (r_state == StBusy && i_eng_ready) begin
                  r_resp_sin   <= i_eng_sin;
                  r_resp_cos   <= i_eng_cos;
                  r_resp_valid <= N'(1) << r_id;
                  r_resp_err   <= 1'b0;
                  r_eng_start  <= 1'b0;
                  r_state      <= StRelease;
               end else if (r_wdog == WdMax) begin
                  r_resp_valid <= N'(1) << r_id;
                  r_resp_err   <= 1'b1;
                  r_eng_start  <= 1'b0;
                  r_eng_rst    <= 1'b1;
                  r_rec_second <= 1'b0;
                  r_state      <= StRecover;
               end else begin
                  r_wdog <= r_wdog + 1'b1;
                  if (r_state == StIssue && !i_eng_ready) r_state <= StBusy;
               end
            end
            StRelease: r_state <= StIdle;
            StRecover: begin
               r_rec_second <= 1'b1;
               if (r_rec_second) begin
                  r_rec_second <= 1'b0;
                  r_eng_rst    <= 1'b0;
                  r_state      <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_req_ready  = w_accept ? w_grant : '0;
   assign o_resp_valid = r_resp_valid;
   assign o_resp_err   = r_resp_err;
   assign o_resp_sin   = r_resp_sin;
   assign o_resp_cos   = r_resp_cos;
   assign o_eng_start  = r_eng_start;
   assign o_eng_angle  = r_angle;
   assign o_eng_reset  = ~i_reset | r_eng_rst;
   assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_cordic_rr_scheduler.sv
// Bench for cordic_rr_scheduler: behavioural engine stub with random latency, stale-ready
// linger and hang mode, plus a scoreboard of accepted jobs checked against golden sin/cos.
module tb_cordic_rr_scheduler;
   import cordic_rr_scheduler_pkg::*;

   localparam int unsigned N       = 4;
   localparam int unsigned W       = CORDIC_W;
   localparam int unsigned TIMEOUT = 255;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N*W-1:0] req_angle;
   logic [N-1:0]   req_ready;
   logic [N-1:0]   resp_valid;
   logic           resp_err;
   logic [W-1:0]   resp_sin;
   logic [W-1:0]   resp_cos;
   logic           eng_start;
   logic [W-1:0]   eng_angle;
   logic           eng_reset;
   logic           eng_ready = 1'b0;
   logic [W-1:0]   eng_sin   = '0;
   logic [W-1:0]   eng_cos   = '0;
   logic           busy;

   always #5 clk = ~clk;

   cordic_rr_scheduler #(
      .N       (N),
      .W       (W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .i_clock      (clk),
      .i_reset      (rst_n),
      .i_req_valid  (req_valid),
      .i_req_angle  (req_angle),
      .o_req_ready  (req_ready),
      .o_resp_valid (resp_valid),
      .o_resp_err   (resp_err),
      .o_resp_sin   (resp_sin),
      .o_resp_cos   (resp_cos),
      .o_eng_start  (eng_start),
      .o_eng_angle  (eng_angle),
      .o_eng_reset  (eng_reset),
      .i_eng_ready  (eng_ready),
      .i_eng_sin    (eng_sin),
      .i_eng_cos    (eng_cos),
      .o_busy       (busy)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] gold_sin(input logic [W-1:0] a);
      real r;
      r = real'($signed(a)) / 1024.0;
      return W'($rtoi($floor($sin(r) * 1024.0 + 0.5)));
   endfunction

   function automatic logic [W-1:0] gold_cos(input logic [W-1:0] a);
      real r;
      r = real'($signed(a)) / 1024.0;
      return W'($rtoi($floor($cos(r) * 1024.0 + 0.5)));
   endfunction

   function automatic bit near(input logic [W-1:0] a, input logic [W-1:0] b);
      int d;
      d = int'($signed(a)) - int'($signed(b));
      return (d <= 4) && (d >= -4);
   endfunction

   // Winner = valid requester at the smallest forward distance from the previous grant.
   function automatic int rr_pick(input int last, input logic [N-1:0] v);
      int best;
      int best_d;
      best   = -1;
      best_d = N + 1;
      for (int i = 0; i < N; i++) begin
         if (v[i] && ((i - last - 1 + 2 * N) % N) < best_d) begin
            best_d = (i - last - 1 + 2 * N) % N;
            best   = i;
         end
      end
      return best;
   endfunction

   function automatic int lowest_bit(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return -1;
   endfunction

   function automatic logic [W-1:0] rand_angle();
      return W'(int'($urandom_range(0, 3216)) - 1608);
   endfunction

   // ---------------- engine stub ----------------
   typedef enum int {ELoad, ECalc, EDone, EReload} eng_st_e;
   eng_st_e     e_st     = ELoad;
   int          e_cnt    = 0;
   int          e_linger = 0;
   logic [W-1:0] e_ang   = '0;
   bit          hang     = 1'b0;
   int          lat_fix  = 0;

   always @(posedge clk) begin
      if (eng_reset) begin
         e_st      <= ELoad;
         eng_ready <= 1'b0;
      end else begin
         case (e_st)
            ELoad: if (eng_start) begin
               e_ang <= eng_angle;
               e_cnt <= (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 10));
               e_st  <= ECalc;
            end
            ECalc: if (!hang) begin
               if (e_cnt <= 1) begin
                  check_eq("eng_start_held", 32'(eng_start), 1);
                  eng_ready <= 1'b1;
                  eng_sin   <= gold_sin(e_ang);
                  eng_cos   <= gold_cos(e_ang);
                  e_st      <= EDone;
               end else begin
                  e_cnt <= e_cnt - 1;
               end
            end
            EDone: if (!eng_start) begin
               e_linger <= int'($urandom_range(0, 2));
               e_st     <= EReload;
            end
            EReload: begin
               if (e_linger == 0) begin
                  eng_ready <= 1'b0;
                  e_st      <= ELoad;
               end else begin
                  e_linger <= e_linger - 1;
               end
            end
            default: e_st <= ELoad;
         endcase
      end
   end

   // ---------------- scoreboard / monitor ----------------
   typedef struct {
      int           id;
      logic [W-1:0] ang;
      bit           err;
      int           cyc;
   } job_t;

   typedef struct {
      int           id;
      logic [W-1:0] ang;
   } req_t;

   job_t         jobs[$];
   req_t         rq[$];
   int           grant_log[$];
   int           model_last = int'(N) - 1;
   int           resp_cnt[N];
   int           err_cnt  = 0;
   logic [W-1:0] last_sin = '0;
   logic [W-1:0] last_cos = '0;
   bit           last_err = 1'b0;
   logic [N-1:0] acc_mask = '0;
   int           rec_len  = 0;
   int           cyc      = 0;
   bit           withdraw_en = 1'b0;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      job_t j;
      int   exp_id;
      int   got_id;
      acc_mask = '0;
      if (!rst_n) begin
         rec_len = 0;
      end else begin
         if (req_ready != '0) begin
            exp_id = rr_pick(model_last, req_valid);
            got_id = lowest_bit(req_ready);
            check_eq("ready_onehot", 32'($onehot(req_ready)), 1);
            check_eq("ready_subset", 32'(req_ready & ~req_valid), 0);
            check_eq("grant_order", 32'(got_id), 32'(exp_id));
            model_last = got_id;
            j.id  = got_id;
            j.ang = req_angle[got_id*W +: W];
            j.err = hang;
            j.cyc = cyc;
            jobs.push_back(j);
            grant_log.push_back(got_id);
            acc_mask = req_ready & req_valid;
         end
         if (resp_valid != '0) begin
            check_eq("resp_onehot", 32'($onehot(resp_valid)), 1);
            if (jobs.size() == 0) begin
               check_eq("resp_spurious", 32'(resp_valid), 0);
            end else begin
               j = jobs.pop_front();
               check_eq("resp_id", 32'(resp_valid), 32'(1) << j.id);
               check_eq("resp_err", 32'(resp_err), 32'(j.err));
               if (j.err) begin
                  err_cnt++;
                  check_eq("wdog_latency",
                           32'((cyc - j.cyc) >= int'(TIMEOUT) && (cyc - j.cyc) <= int'(TIMEOUT) + 4),
                           1);
               end else begin
                  check_eq("resp_sin", 32'(resp_sin), 32'(gold_sin(j.ang)));
                  check_eq("resp_cos", 32'(resp_cos), 32'(gold_cos(j.ang)));
               end
               resp_cnt[j.id]++;
               last_sin = resp_sin;
               last_cos = resp_cos;
               last_err = resp_err;
            end
         end
         if (eng_reset) begin
            check_eq("rec_start_low", 32'(eng_start), 0);
            rec_len++;
         end else if (rec_len != 0) begin
            check_eq("rec_len", 32'(rec_len), 2);
            rec_len = 0;
         end
      end
   end

   // ---------------- drivers ----------------
   task automatic tick();
      bit found;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         if (acc_mask[i]) begin
            req_valid[i] = 1'b0;
            req_angle[i*W +: W] = W'($urandom);
         end else if (req_valid[i] && withdraw_en && $urandom_range(0, 19) == 0) begin
            req_valid[i] = 1'b0;
            continue;
         end
         if (!req_valid[i]) begin
            found = 1'b0;
            for (int k = 0; k < rq.size(); k++) begin
               if (!found && rq[k].id == i) begin
                  req_valid[i]        = 1'b1;
                  req_angle[i*W +: W] = rq[k].ang;
                  rq.delete(k);
                  found = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic push_req(input int id, input logic [W-1:0] ang);
      req_t r;
      r.id  = id;
      r.ang = ang;
      rq.push_back(r);
   endtask

   task automatic drain(input string tag, input int budget);
      int c;
      c = 0;
      while ((jobs.size() != 0 || rq.size() != 0 || req_valid != '0) && c < budget) begin
         tick();
         c++;
      end
      check_eq(tag, 32'(c < budget), 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq({tag, "_req_ready"},  32'(req_ready), 0);
      check_eq({tag, "_resp_valid"}, 32'(resp_valid), 0);
      check_eq({tag, "_resp_err"},   32'(resp_err), 0);
      check_eq({tag, "_eng_start"},  32'(eng_start), 0);
      check_eq({tag, "_busy"},       32'(busy), 0);
      check_eq({tag, "_resp_sin"},   32'(resp_sin), 0);
      check_eq({tag, "_resp_cos"},   32'(resp_cos), 0);
      check_eq({tag, "_eng_reset"},  32'(eng_reset), 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish, expected finish");
      $fatal(1);
   end

   initial begin
      int snap[N];
      int c;
      req_valid = '0;
      req_angle = '0;
      rst_n     = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      check_reset_outputs("rst");
      tick();
      rst_n = 1'b1;

      // single request at pi/4
      push_req(0, PI_4);
      drain("t1_drain", 200);
      check_eq("t1_sin_near", 32'(near(last_sin, 12'h2D4)), 1);
      check_eq("t1_cos_near", 32'(near(last_cos, 12'h2D4)), 1);
      check_eq("t1_err", 32'(last_err), 0);
      check_eq("t1_count", 32'(resp_cnt[0]), 1);

      // angle zero on requester 2
      for (int i = 0; i < N; i++) snap[i] = resp_cnt[i];
      push_req(2, 12'h000);
      drain("t2_drain", 200);
      check_eq("t2_sin_near", 32'(near(last_sin, 12'h000)), 1);
      check_eq("t2_cos_near", 32'(near(last_cos, ONE)), 1);
      check_eq("t2_count", 32'(resp_cnt[2] - snap[2]), 1);
      check_eq("t2_others", 32'((resp_cnt[0] - snap[0]) + (resp_cnt[1] - snap[1]) +
                                (resp_cnt[3] - snap[3])), 0);

      // back-to-back on requester 1; second result must not be the stale first
      push_req(1, 12'h100);
      push_req(1, 12'h200);
      drain("t4_drain", 300);
      check_eq("t4_sin2", 32'(last_sin), 32'(gold_sin(12'h200)));
      check_eq("t4_cos2", 32'(last_cos), 32'(gold_cos(12'h200)));

      // hung engine, then normal recovery
      hang = 1'b1;
      push_req(3, rand_angle());
      drain("t5_hang_drain", 400);
      hang = 1'b0;
      check_eq("t5_err_count", 32'(err_cnt), 1);
      check_eq("t5_err_flag", 32'(last_err), 1);
      push_req(3, 12'h200);
      drain("t5_after_drain", 200);
      check_eq("t5_after_err", 32'(last_err), 0);
      check_eq("t5_after_sin", 32'(last_sin), 32'(gold_sin(12'h200)));

      // reset while the engine is busy
      lat_fix = 20;
      push_req(2, rand_angle());
      c = 0;
      while (jobs.size() == 0 && c < 100) begin
         tick();
         c++;
      end
      check_eq("t6_accept", 32'(c < 100), 1);
      repeat (4) tick();
      @(negedge clk);
      check_eq("t6_busy_before", 32'(busy), 1);
      tick();
      rst_n     = 1'b0;
      req_valid = '0;
      rq.delete();
      tick();
      @(negedge clk);
      check_reset_outputs("t6");
      jobs.delete();
      model_last = int'(N) - 1;
      lat_fix    = 0;

      // all requesters held from reset release
      for (int i = 0; i < N; i++) begin
         snap[i] = resp_cnt[i];
         req_valid[i] = 1'b1;
         req_angle[i*W +: W] = rand_angle();
         push_req(i, rand_angle());
      end
      grant_log.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      drain("t3_drain", 1000);
      check_eq("t3_log_len", 32'(grant_log.size() >= 5), 1);
      if (grant_log.size() >= 5) begin
         check_eq("t3_g0", 32'(grant_log[0]), 0);
         check_eq("t3_g1", 32'(grant_log[1]), 1);
         check_eq("t3_g2", 32'(grant_log[2]), 2);
         check_eq("t3_g3", 32'(grant_log[3]), 3);
         check_eq("t3_g4", 32'(grant_log[4]), 0);
      end
      for (int i = 0; i < N; i++) check_eq("t3_count", 32'(resp_cnt[i] - snap[i]), 2);

      // randomized traffic with occasional withdrawals
      withdraw_en = 1'b1;
      for (int n = 0; n < 60; n++) begin
         push_req(int'($urandom_range(0, N - 1)), rand_angle());
         repeat ($urandom_range(0, 6)) tick();
      end
      drain("rand_drain", 4000);
      withdraw_en = 1'b0;
      repeat (4) tick();
      check_eq("final_idle", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
